// File: rtl/trojan_guarded_alu.sv
// trojan_guarded_alu: registered ALU with shadow datapath, trigger detection and lockout FSM.
// Define TROJAN_MODEL_EN to plant the modelled Trojan in the primary datapath.
module trojan_guarded_alu_core #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] TRIG_A = 8'hA5,
    parameter logic [WIDTH-1:0] TRIG_B = 8'h5A,
    parameter bit TROJAN = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       opcode,
    output logic [WIDTH-1:0] res,
    output logic             cy
);
    logic [WIDTH:0] ext;
    logic           hit;
    always_comb begin
        ext = opcode == 2'b00 ? {1'b0, a} + {1'b0, b} :
              opcode == 2'b01 ? {1'b0, a} - {1'b0, b} :
              opcode == 2'b10 ? {1'b0, a & b} : {1'b0, a ^ b};
        hit = TROJAN && opcode == 2'b11 && a == ~TRIG_A && b == ~TRIG_B;
        res = hit ? '0 : ext[WIDTH-1:0];
        cy  = ext[WIDTH];
    end
endmodule

module trojan_guarded_alu #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] TRIG_A = 8'hA5,
    parameter logic [WIDTH-1:0] TRIG_B = 8'h5A,
    parameter int ALERT_THRESH = 3,
    parameter int QUIET_CYCLES = 8,
    parameter int LOCK_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       opcode,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             detect,
    output logic             mitigation_active,
    output logic             locked,
    output logic [7:0]       det_count
);
`ifdef TROJAN_MODEL_EN
    localparam bit TROJAN = 1'b1;
`else
    localparam bit TROJAN = 1'b0;
`endif
    localparam int EW = $clog2(ALERT_THRESH + 1);
    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {NORMAL, ALERT, LOCKOUT, RECOVER} state_t;
    state_t state, ns;
    logic [EW-1:0] ep;
    logic [QW-1:0] qt;
    logic [LW-1:0] lt;
    logic [WIDTH-1:0] p_res, s_res, out_res;
    logic p_cy, s_cy, acc, det;

    trojan_guarded_alu_core #(.WIDTH(WIDTH), .TRIG_A(TRIG_A), .TRIG_B(TRIG_B), .TROJAN(TROJAN)) u_primary (
        .a(a), .b(b), .opcode(opcode), .res(p_res), .cy(p_cy)
    );
    trojan_guarded_alu_core #(.WIDTH(WIDTH), .TRIG_A(TRIG_A), .TRIG_B(TRIG_B), .TROJAN(1'b0)) u_shadow (
        .a(a), .b(b), .opcode(opcode), .res(s_res), .cy(s_cy)
    );

    always_comb begin
        acc     = in_valid & in_ready;
        det     = acc & ({p_res, p_cy} != {s_res, s_cy} || (opcode == 2'b11 && a == TRIG_A && b == TRIG_B));
        out_res = det ? s_res : p_res;
        ns      = state;
        case (state)
            NORMAL:  ns = det ? (ALERT_THRESH == 1 ? LOCKOUT : ALERT) : NORMAL;
            ALERT:   ns = det ? (ep + EW'(1) == EW'(ALERT_THRESH) ? LOCKOUT : ALERT) :
                           (qt == QW'(QUIET_CYCLES - 1) ? NORMAL : ALERT);
            LOCKOUT: ns = lt == LW'(LOCK_CYCLES - 1) ? RECOVER : LOCKOUT;
            default: ns = NORMAL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= NORMAL;
            ep                <= '0;
            qt                <= '0;
            lt                <= '0;
            in_ready          <= 1'b1;
            locked            <= 1'b0;
            mitigation_active <= 1'b0;
        end else begin
            state             <= ns;
            ep                <= (ns == NORMAL || ns == RECOVER) ? '0 : det ? ep + EW'(1) : ep;
            qt                <= (state == ALERT && ns == ALERT && !det) ? qt + QW'(1) : '0;
            lt                <= (state == LOCKOUT && ns == LOCKOUT) ? lt + LW'(1) : '0;
            in_ready          <= ns != LOCKOUT && ns != RECOVER;
            locked            <= ns == LOCKOUT;
            mitigation_active <= ns != NORMAL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            detect    <= 1'b0;
            det_count <= '0;
        end else begin
            out_valid <= acc;
            if (acc) begin
                result <= out_res;
                carry  <= det ? s_cy : p_cy;
                zero   <= out_res == '0;
                detect <= det;
            end
            if (det && det_count != 8'hFF) det_count <= det_count + 8'd1;
        end
    end
endmodule

// File: doc/trojan_guarded_alu.md
Name: trojan_guarded_alu

Overview:
Parametrised, registered successor to the combinational Trojan-protected ALU. It computes each operation on a primary datapath and an independent shadow datapath, and flags a detection on mismatch or on a trigger-pattern match. On detection it forces the corrected result out, and escalates through a mitigation FSM that can lock out further input. It sits between the operand issue logic and the result consumer, using a valid/ready input handshake.

Parameters:
WIDTH, 8, operand/result width in bits (>=4)
TRIG_A, 8'hA5, watched trigger value for operand a (WIDTH bits)
TRIG_B, 8'h5A, watched trigger value for operand b (WIDTH bits)
ALERT_THRESH, 3, detections within one alert episode that force LOCKOUT (>=1)
QUIET_CYCLES, 8, detection-free cycles in ALERT before returning to NORMAL
LOCK_CYCLES, 16, cycles spent in LOCKOUT before RECOVER

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operand/opcode valid
in_ready  out  1  block accepts operands; 0 only in LOCKOUT and RECOVER
a  in  WIDTH  operand a
b  in  WIDTH  operand b
opcode  in  2  00 add, 01 sub, 10 and, 11 xor
out_valid  out  1  one-cycle pulse: result registers valid
result  out  WIDTH  registered result, corrected when detected
carry  out  1  add carry-out / sub borrow; 0 for and/xor
zero  out  1  result == 0 (informational only, never a detection)
detect  out  1  registered detection flag for this result
mitigation_active  out  1  state != NORMAL
locked  out  1  state == LOCKOUT
det_count  out  8  saturating total detections since reset

Behaviour:
- Accept = in_valid & in_ready. Latency 1: result/carry/zero/detect are registered on the accept edge; out_valid is high the following cycle only. No output backpressure.
- Arithmetic: add/sub are computed at WIDTH+1 bits. result = low WIDTH bits (modulo 2^WIDTH). carry = bit WIDTH for add; for sub, carry = 1 when a < b (unsigned).
- The shadow path is a separate, functionally identical ALU instance. Its result is the golden value.
- Detection (combinational on accept) = (primary != shadow) | (opcode==11 & a==TRIG_A & b==TRIG_B).
- On detection: result <= shadow result, detect <= 1, det_count increments (saturates at 255).
- Outputs that are not accepted hold their last value. detect is cleared on the next accept without detection.
- FSM states and transitions:
  - NORMAL: on a detected accept -> ALERT, with episode count = 1.
  - ALERT: each detected accept increments episode count and reloads the quiet timer. If the new count == ALERT_THRESH -> LOCKOUT. If there is no detection for QUIET_CYCLES consecutive cycles -> NORMAL, and episode count clears.
  - LOCKOUT: in_ready = 0; lock timer counts LOCK_CYCLES cycles, then -> RECOVER.
  - RECOVER: one cycle; in_ready = 0; episode count and timers clear; -> NORMAL.
- If ALERT_THRESH == 1, NORMAL goes directly to LOCKOUT on a detected accept.
- The accept that causes the LOCKOUT transition still produces its (corrected) output.
- Quiet-timer expiry and a detection in the same cycle: detection wins (stay in ALERT, timer reloads).
- Reset (asynchronous, at any time, including mid-LOCKOUT): state = NORMAL, and all outputs = 0 except in_ready = 1. That is, out_valid, result, carry, zero, detect, mitigation_active, locked and det_count are all 0. All timers and counters are 0.

Optional Feature:
Macro TROJAN_MODEL_EN.
- Defined: the primary datapath contains the modelled Trojan. For opcode 11 with a == ~TRIG_A and b == ~TRIG_B, the primary result is forced to 0. This gives a mismatch-only detection path for verification.
- Not defined: the primary path is clean, so only the trigger-pattern match can raise a detection.

Test Plan:
1. After reset: a=8'h0F, b=8'h01, op 00 -> next cycle out_valid=1, result=8'h10, carry=0, detect=0, mitigation_active=0.
2. Wrap and zero: a=8'hFF, b=8'h01, op 00 -> result=8'h00, carry=1, zero=1, detect=0, state stays NORMAL. Then a=8'h00, b=8'h01, op 01 -> result=8'hFF, carry=1.
3. Trigger: a=8'hA5, b=8'h5A, op 11 -> result=8'hFF (corrected), detect=1, det_count=1, mitigation_active=1. Then 8 idle cycles -> mitigation_active=0.
4. With TROJAN_MODEL_EN defined: a=8'h5A, b=8'hA5, op 11 -> result=8'hFF, detect=1. Without the macro, the same stimulus gives detect=0.
5. Lockout: three trigger ops on consecutive cycles -> the third output still valid, then locked=1 and in_ready=0 for 16 cycles, then 1 RECOVER cycle, then in_ready=1, mitigation_active=0, det_count=3.
6. Reset asserted mid-LOCKOUT (cycle 5) -> outputs clear immediately (asynchronously), with no clock edge needed. After release, in_ready=1 and the first op completes normally.
